// File: rtl/serial_adder.sv
// Bit-serial adder: operands are loaded in parallel, summed LSB first through one
// full-adder slice over N cycles, and the result is held under a valid/ready handshake.
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int             CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [N-1:0]   sum_sh;
  logic [N-1:0]   sum_shifted;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           last_bit;
  logic           bit_s;
  logic           bit_c;

  // Single full-adder slice working on the current LSBs and the carry flop.
  assign bit_s       = a_sh[0] ^ b_sh[0] ^ carry;
  assign bit_c       = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign sum_shifted = N'({bit_s, sum_sh} >> 1);
  assign last_bit    = (cnt == LAST);
  assign accept      = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: each combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (in_valid)  state_next = RUN;
      RUN:  if (last_bit)  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath. sum/cout are separate output registers, loaded only on the final
  // RUN cycle, so the previous result stays visible until a new one replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_shifted;
      carry  <= bit_c;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        sum  <= sum_shifted;
        cout <= bit_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table at N=8, backpressure,
// mid-operation reset, randomized handshakes, and the N=1 truth table.
module tb_serial_adder;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         busy;

  logic in_valid_1, in_ready_1, a_1, b_1, cin_1, out_valid_1, out_ready_1;
  logic sum_1, cout_1, busy_1;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  int n_done = 0;

  serial_adder #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_adder #(.N(1)) dut_1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .a(a_1), .b(b_1), .cin(cin_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
    .sum(sum_1), .cout(cout_1), .busy(busy_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready)   n_acc  <= n_acc + 1;
      if (out_valid && out_ready) n_done <= n_done + 1;
    end
  end

  typedef struct {
    logic [N-1:0] va;
    logic [N-1:0] vb;
    logic         vcin;
    logic [N-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full transaction on the N=8 instance. hold = DONE cycles with out_ready low
  // (ignored when pre_ready); junk = keep in_valid high with changing operands during RUN.
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tc,
                        input logic [N-1:0] exp_s, input logic exp_c,
                        input int hold, input bit pre_ready, input bit junk);
    int lat;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = pre_ready;
    check("ready_before_accept", in_ready, 1);
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    check("no_ready_in_run", in_ready, 0);
    if (!junk) in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (junk) begin a = N'($urandom); b = N'($urandom); cin = 1'($urandom); end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, N);
    check("sum", sum, exp_s);
    check("cout", cout, exp_c);
    if (!pre_ready) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_sum", {cout, sum}, {exp_c, exp_s});
        check("hold_no_ready", in_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("idle_ready", in_ready, 1);
    check("idle_no_valid", out_valid, 0);
    check("idle_keeps_result", {cout, sum}, {exp_c, exp_s});
    out_ready = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    int acc0, done0, ones;
    logic [N:0] model;
    bit saw_valid;

    vecs[0] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid_1 = 1'b0; out_ready_1 = 1'b0; a_1 = 1'b0; b_1 = 1'b0; cin_1 = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum_cout", {cout, sum}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, alternating between out_ready preset and late out_ready.
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].exp_sum, vecs[i].exp_cout,
             0, (i % 2) == 0, 1'b0);

    // Backpressure for five DONE cycles.
    run_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 5, 1'b0, 1'b0);
    // Operands changing with in_valid high during RUN must not disturb the result.
    run_op(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 2, 1'b0, 1'b1);
    run_op(8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 0, 1'b1, 1'b0);

    // Reset three cycles into RUN; the previous result 0xFF must be cleared.
    @(negedge clk);
    a = 8'h3C; b = 8'h0F; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_sum_cout", {cout, sum}, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid || busy) saw_valid = 1'b1;
    end
    check("no_valid_after_reset", saw_valid, 0);
    run_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1, 1'b0, 1'b0);

    // Randomized transactions against an arithmetic reference.
    acc0 = n_acc; done0 = n_done;
    for (int t = 0; t < 1000; t++) begin
      logic [N-1:0] ra, rb;
      logic rc;
      ra = N'($urandom); rb = N'($urandom); rc = 1'($urandom);
      model = {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(ra, rb, rc, model[N-1:0], model[N], $urandom_range(0, 3),
             1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    check("random_accepts", n_acc - acc0, 1000);
    check("random_completions", n_done - done0, 1000);

    // N=1 instance: full-adder truth table, result one cycle after acceptance.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      ones = int'(v[2]) + int'(v[1]) + int'(v[0]);
      @(negedge clk);
      a_1 = v[2]; b_1 = v[1]; cin_1 = v[0]; in_valid_1 = 1'b1; out_ready_1 = 1'b1;
      check("n1_ready", in_ready_1, 1);
      @(negedge clk);
      in_valid_1 = 1'b0;
      check("n1_busy", busy_1, 1);
      @(negedge clk);
      check("n1_valid", out_valid_1, 1);
      check("n1_sum", sum_1, ones % 2);
      check("n1_cout", cout_1, ones >= 2);
      @(negedge clk);
      check("n1_idle", in_ready_1, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand set presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  N  operand A.
REQ-007 SHALL have port b  input  N  operand B.
REQ-008 SHALL have port cin  input  1  carry-in.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port sum  output  N  result, (a+b+cin) mod 2^N.
REQ-012 SHALL have port cout  output  1  carry out of bit N-1.
REQ-013 SHALL have port busy  output  1  high in RUN state.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; in_ready=1 only in IDLE, busy=1 only in RUN, out_valid=1 only in DONE.
REQ-015 SHALL accept operands on a rising edge with in_valid=1 and in_ready=1: a, b into shift registers, cin into the carry flop, bit counter cleared, state -> RUN.
REQ-016 SHALL, in RUN, process one bit per cycle, LSB first, through a single full-adder slice: s = a0^b0^c, c_next = a0&b0 | a0&c | b0&c.
REQ-017 SHALL, per RUN cycle, shift the a and b registers right by one, shift s into the MSB of the sum register, update the carry flop, and increment the counter.
REQ-018 SHALL leave RUN after exactly N RUN cycles; out_valid SHALL rise N cycles after the acceptance edge, with sum and cout = final carry.
REQ-019 SHALL hold sum, cout and out_valid stable in DONE until a rising edge with out_ready=1, then go to IDLE (in_ready=1 the next cycle).
REQ-020 SHALL NOT accept operands in RUN or DONE; in_valid is ignored there and a/b/cin changes after acceptance have no effect.
REQ-021 SHALL keep the last sum/cout visible on the outputs after DONE->IDLE until the next result overwrites them (not zeroed).
REQ-022 SHALL support N=1: one RUN cycle, result identical to a combinational full adder.
REQ-023 SHALL sustain a maximum throughput of one operation per N+2 cycles (accept, N RUN cycles, DONE handshake with out_ready already high).
REQ-024 SHALL tolerate out_ready=1 before out_valid rises; the result SHALL still be presented for at least one cycle.

Reset
REQ-025 SHALL, while rst_n=0 (asynchronously), force state=IDLE, sum=0, cout=0, carry flop=0, counter=0, operand registers=0, out_valid=0, busy=0.
REQ-026 SHALL drive in_ready=1 during and after reset.
REQ-027 SHALL discard any operation in progress on reset and emit no out_valid for it after reset release.

Verification
REQ-028 SHALL pass, with N=8: a=0x5A, b=0xA5, cin=1 accepted -> 8 cycles later out_valid=1, sum=0x00, cout=1.
REQ-029 SHALL pass, with N=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0; a=0x12, b=0x34, cin=1 -> sum=0x47, cout=0.
REQ-030 SHALL pass backpressure: out_ready held 0 for 5 cycles after out_valid -> sum/cout/out_valid unchanged and in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-031 SHALL pass reset mid-operation: rst_n pulsed low after 3 RUN cycles -> all outputs zero immediately, in_ready=1, no out_valid until a new operand set is accepted.
REQ-032 SHALL pass a random test: 1000 transactions with random a, b, cin, random in_valid/out_ready gaps and in_valid held high during RUN -> each {cout,sum} equals a+b+cin from a reference model, with no extra or lost transactions.
REQ-033 SHALL pass the N=1 case: all 8 combinations of a, b, cin -> sum/cout match the full-adder truth table, each one cycle after acceptance.
